// File: rtl/spiflash_pkg.sv
// -----------------------------------------------------------------------------
// spiflash_pkg
// Shared definitions for the SPI-flash boot loader: the READ opcode, the
// bit counts of each phase of the flash transaction, the controller state
// encoding and a small helper that sizes the clock-divider counters.
// No ports (package).
// -----------------------------------------------------------------------------
package spiflash_pkg;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int WORD_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    ADDR,
    DATA,
    HOLD,
    FIN
  } state_t;

  // Width of a counter that must reach div-1; never narrower than one bit.
  function automatic int div_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/spiflash_loader_spi_sck_gen.sv
// -----------------------------------------------------------------------------
// spi_sck_gen
// Mode-0 SPI clock generator. While enabled, each bit is CLK_DIV cycles of
// spiclk low followed by CLK_DIV cycles high. rise_stb / fall_stb are high in
// the single ap_clk cycle at whose end spiclk goes high / low, so the
// controller samples MISO on rise_stb and advances MOSI on fall_stb.
// When disabled the counter is held at 0 and spiclk is parked low, so every
// enable starts with a full low half-period.
//
// Ports:
//   ap_clk    in   clock
//   ap_rst    in   asynchronous active-high reset
//   en        in   run the divider
//   spiclk    out  SPI clock (registered)
//   rise_stb  out  spiclk rises at the end of this cycle
//   fall_stb  out  spiclk falls at the end of this cycle
// -----------------------------------------------------------------------------
module spi_sck_gen
  import spiflash_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic en,
  output logic spiclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int               DIV_W    = div_cnt_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             sck_reg;
  logic             phase_end;

  assign phase_end = (div_cnt_reg == DIV_LAST);
  assign rise_stb  = en & ~sck_reg & phase_end;
  assign fall_stb  = en &  sck_reg & phase_end;
  assign spiclk    = sck_reg;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      div_cnt_reg <= '0;
      sck_reg     <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      sck_reg     <= 1'b0;
    end else if (phase_end) begin
      div_cnt_reg <= '0;
      sck_reg     <= ~sck_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spiflash_loader.sv
// -----------------------------------------------------------------------------
// spiflash_loader
// SPI-flash read initiator. On an accepted start it selects the flash, sends
// READ (0x03) and a 24-bit byte address MSB first, then clocks in word_count
// 32-bit words. Each word is assembled little-endian (first byte received in
// bits [7:0]) and written into a BRAM port at byte address idx*4, idx
// counting from 0. The write pulse overlaps the next bit; SPI timing never
// stalls.
//
// Ports:
//   ap_clk, ap_rst        clock, asynchronous active-high reset
//   start                 one-cycle request, honoured only in IDLE
//   flash_base[23:0]      flash byte address, latched on accepted start
//   word_count[CNT_W-1:0] words to load, latched on accepted start
//   busy, done            transfer in progress / one-cycle completion pulse
//   csb, spiclk, io0, io1 flash chip select (low), mode-0 clock, MOSI, MISO
//   romcode_*_A           BRAM write port; Dout unused, Clk/Rst pass through
// -----------------------------------------------------------------------------
module spiflash_loader
  import spiflash_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             start,
  input  logic [23:0]      flash_base,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             csb,
  output logic             spiclk,
  output logic             io0,
  input  logic             io1,
  output logic [31:0]      romcode_Addr_A,
  output logic             romcode_EN_A,
  output logic [3:0]       romcode_WEN_A,
  output logic [31:0]      romcode_Din_A,
  input  logic [31:0]      romcode_Dout_A,
  output logic             romcode_Clk_A,
  output logic             romcode_Rst_A
);

  localparam int               DIV_W     = div_cnt_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       CMD_LAST  = 5'(CMD_BITS - 1);
  localparam logic [4:0]       ADDR_LAST = 5'(ADDR_BITS - 1);
  localparam logic [4:0]       WORD_LAST = 5'(WORD_BITS - 1);

  state_t                 state_reg;
  logic [DIV_W-1:0]       wait_cnt_reg;
  logic [4:0]             bit_cnt_reg;
  logic [31:0]            tx_reg;
  logic [WORD_BITS-1:0]   rx_reg;
  logic [CNT_W-1:0]       wc_reg;
  logic [CNT_W-1:0]       idx_reg;
  logic                   csb_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   en_reg;
  logic [31:0]            addr_reg;
  logic [31:0]            din_reg;

  logic                   sck_en;
  logic                   rise_stb;
  logic                   fall_stb;
  logic [WORD_BITS-1:0]   rx_next;
  logic [WORD_BITS-1:0]   word_le;
  logic                   unused_dout;

  assign sck_en = (state_reg == CMD) || (state_reg == ADDR) || (state_reg == DATA);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .en       (sck_en),
    .spiclk   (spiclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Bits arrive MSB first, so the first byte of a word ends up in the top
  // byte of the shift register; swap bytes to land it in Din[7:0].
  assign rx_next = {rx_reg[WORD_BITS-2:0], io1};

  genvar gi;
  for (gi = 0; gi < WORD_BITS / 8; gi++) begin : g_bswap
    assign word_le[8*gi +: 8] = rx_next[WORD_BITS-8-8*gi +: 8];
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      wc_reg       <= '0;
      idx_reg      <= '0;
      csb_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      en_reg       <= 1'b0;
      addr_reg     <= '0;
      din_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      en_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            wc_reg  <= word_count;
            idx_reg <= '0;
            if (word_count == '0) begin
              // Nothing to fetch: finish without touching the flash bus.
              state_reg <= FIN;
              done_reg  <= 1'b1;
            end else begin
              state_reg    <= SETUP;
              busy_reg     <= 1'b1;
              csb_reg      <= 1'b0;
              tx_reg       <= {FLASH_CMD_READ, flash_base};
              wait_cnt_reg <= '0;
            end
          end
        end
        SETUP: begin
          if (wait_cnt_reg == DIV_LAST) begin
            state_reg    <= CMD;
            wait_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        CMD: begin
          if (fall_stb) begin
            tx_reg <= {tx_reg[30:0], 1'b0};
            if (bit_cnt_reg == CMD_LAST) begin
              state_reg   <= ADDR;
              bit_cnt_reg <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        ADDR: begin
          // Zero fill leaves tx_reg empty once the address is out, so MOSI
          // sits at 0 for the whole data phase.
          if (fall_stb) begin
            tx_reg <= {tx_reg[30:0], 1'b0};
            if (bit_cnt_reg == ADDR_LAST) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (rise_stb) begin
            rx_reg <= rx_next;
            if (bit_cnt_reg == WORD_LAST) begin
              bit_cnt_reg <= '0;
              en_reg      <= 1'b1;
              addr_reg    <= 32'(idx_reg) << 2;
              din_reg     <= word_le;
              idx_reg     <= idx_reg + 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
          // bit_cnt is 0 at a fall only right after a word completed; idx has
          // then already moved past the final word when the load is over.
          if (fall_stb && (bit_cnt_reg == '0) && (idx_reg == wc_reg)) begin
            state_reg    <= HOLD;
            wait_cnt_reg <= '0;
          end
        end
        HOLD: begin
          if (wait_cnt_reg == DIV_LAST) begin
            state_reg <= FIN;
            csb_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_reg;
  assign done           = done_reg;
  assign csb            = csb_reg;
  assign io0            = tx_reg[31];
  assign romcode_Addr_A = addr_reg;
  assign romcode_EN_A   = en_reg;
  assign romcode_WEN_A  = {4{en_reg}};
  assign romcode_Din_A  = din_reg;
  assign romcode_Clk_A  = ap_clk;
  assign romcode_Rst_A  = ap_rst;

  // Read data port exists only so the BRAM interface is complete.
  assign unused_dout = ^romcode_Dout_A;

endmodule

// File: tb/tb_spiflash_loader.sv
// -----------------------------------------------------------------------------
// tb_spiflash_loader
// Two loaders share one clock: instance 0 with CLK_DIV=4, instance 1 with
// CLK_DIV=1. A behavioural flash (byte array plus bit counting on spiclk
// edges) answers each instance; expected BRAM writes are computed directly
// from the flash contents and the requested base/count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spiflash_loader;

  localparam int CNT_W = 16;
  localparam int N_DUT = 2;
  localparam int MEM_N = 1024;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic             start_w [N_DUT];
  logic [23:0]      base_w  [N_DUT];
  logic [CNT_W-1:0] wc_w    [N_DUT];
  logic             busy_w  [N_DUT];
  logic             done_w  [N_DUT];
  logic             csb_w   [N_DUT];
  logic             sck_w   [N_DUT];
  logic             io0_w   [N_DUT];
  logic             io1_w   [N_DUT];
  logic [31:0]      addr_w  [N_DUT];
  logic             en_w    [N_DUT];
  logic [3:0]       wen_w   [N_DUT];
  logic [31:0]      din_w   [N_DUT];
  logic             rclk_w  [N_DUT];
  logic             rrst_w  [N_DUT];
  logic [31:0]      dout_c = 32'h0;

  genvar gi;
  generate
    for (gi = 0; gi < N_DUT; gi++) begin : g_dut
      spiflash_loader #(
        .CLK_DIV ((gi == 0) ? 4 : 1),
        .CNT_W   (CNT_W)
      ) u_dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .start          (start_w[gi]),
        .flash_base     (base_w[gi]),
        .word_count     (wc_w[gi]),
        .busy           (busy_w[gi]),
        .done           (done_w[gi]),
        .csb            (csb_w[gi]),
        .spiclk         (sck_w[gi]),
        .io0            (io0_w[gi]),
        .io1            (io1_w[gi]),
        .romcode_Addr_A (addr_w[gi]),
        .romcode_EN_A   (en_w[gi]),
        .romcode_WEN_A  (wen_w[gi]),
        .romcode_Din_A  (din_w[gi]),
        .romcode_Dout_A (dout_c),
        .romcode_Clk_A  (rclk_w[gi]),
        .romcode_Rst_A  (rrst_w[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int clk_div(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // ------------------------------------------------------- reference model
  logic [7:0]  mem [MEM_N];
  logic [31:0] exp_a [16];
  logic [31:0] exp_d [16];
  int          exp_n = 0;
  int          wr_base [N_DUT] = '{0, 0};

  function automatic logic flash_bit(input logic [23:0] a, input int d);
    logic [7:0] b;
    b = mem[(int'(a) + d / 8) % MEM_N];
    return b[7 - (d % 8)];
  endfunction

  // ---------------------------------------------------- flash + bus monitor
  int          cyc = 0;
  int          rise_cnt  [N_DUT] = '{0, 0};
  logic [31:0] cmdaddr   [N_DUT] = '{32'h0, 32'h0};
  int          csb_low   [N_DUT] = '{0, 0};
  int          last_low  [N_DUT] = '{0, 0};
  int          csb_falls [N_DUT] = '{0, 0};
  int          sck_tog   [N_DUT] = '{0, 0};
  int          wr_cnt    [N_DUT] = '{0, 0};
  int          last_rise [N_DUT] = '{-1, -1};
  int          per_min   [N_DUT] = '{0, 0};
  int          per_max   [N_DUT] = '{0, 0};
  logic        prev_csb  [N_DUT] = '{1'b1, 1'b1};
  logic        prev_sck  [N_DUT] = '{1'b0, 1'b0};

  initial begin
    for (int k = 0; k < N_DUT; k++) io1_w[k] = 1'b0;
  end

  always @(negedge ap_clk) begin : mon
    int gap;
    int idx;
    cyc++;
    for (int k = 0; k < N_DUT; k++) begin
      if (!csb_w[k] && prev_csb[k]) begin
        csb_low[k]   = 0;
        rise_cnt[k]  = 0;
        csb_falls[k] = csb_falls[k] + 1;
        per_min[k]   = 1 << 30;
        per_max[k]   = 0;
        last_rise[k] = -1;
      end
      if (!csb_w[k]) csb_low[k] = csb_low[k] + 1;
      if (csb_w[k] && !prev_csb[k]) last_low[k] = csb_low[k];
      if (sck_w[k] !== prev_sck[k]) sck_tog[k] = sck_tog[k] + 1;
      if (sck_w[k] && !prev_sck[k] && !csb_w[k]) begin
        if (rise_cnt[k] < 32) cmdaddr[k] = {cmdaddr[k][30:0], io0_w[k]};
        if (last_rise[k] >= 0) begin
          gap = cyc - last_rise[k];
          if (gap < per_min[k]) per_min[k] = gap;
          if (gap > per_max[k]) per_max[k] = gap;
        end
        last_rise[k] = cyc;
        rise_cnt[k]  = rise_cnt[k] + 1;
      end
      // Flash shifts out data on the falling edge once READ + address are in.
      if (!sck_w[k] && prev_sck[k] && !csb_w[k] && rise_cnt[k] >= 32)
        io1_w[k] = flash_bit(cmdaddr[k][23:0], rise_cnt[k] - 32);
      if (en_w[k]) begin
        idx = wr_cnt[k] - wr_base[k];
        $display("dut%0d write #%0d addr=0x%08h din=0x%08h wen=%h", k, idx, addr_w[k], din_w[k], wen_w[k]);
        if (idx >= 0 && idx < exp_n) begin
          check($sformatf("wr_addr%0d_%0d", k, idx), addr_w[k], exp_a[idx]);
          check($sformatf("wr_din%0d_%0d", k, idx), din_w[k], exp_d[idx]);
          check($sformatf("wr_wen%0d_%0d", k, idx), wen_w[k], 4'hF);
        end else begin
          check($sformatf("unexpected_wr%0d", k), 1'b1, 1'b0);
        end
        wr_cnt[k] = wr_cnt[k] + 1;
      end
      prev_csb[k] = csb_w[k];
      prev_sck[k] = sck_w[k];
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic load_model(input int k, input logic [23:0] base, input int wc);
    int b;
    b = int'(base);
    exp_n = wc;
    for (int i = 0; i < wc; i++) begin
      exp_a[i] = 32'(i * 4);
      exp_d[i] = {mem[(b + 4*i + 3) % MEM_N], mem[(b + 4*i + 2) % MEM_N],
                  mem[(b + 4*i + 1) % MEM_N], mem[(b + 4*i) % MEM_N]};
    end
    wr_base[k] = wr_cnt[k];
  endtask

  task automatic run_xfer(input int k, input logic [23:0] base, input int wc, input int restart_at);
    int d;
    int cycles;
    int limit;
    d     = clk_div(k);
    limit = (32 + 32 * wc) * 2 * d + 2 * d + 20;
    load_model(k, base, wc);
    @(negedge ap_clk);
    base_w[k]  = base;
    wc_w[k]    = CNT_W'(wc);
    start_w[k] = 1'b1;
    @(negedge ap_clk);
    start_w[k] = 1'b0;
    check($sformatf("busy_after_start%0d", k), busy_w[k], 1'b1);
    check($sformatf("csb_after_start%0d", k), csb_w[k], 1'b0);
    cycles = 0;
    while (!done_w[k] && cycles < limit) begin
      @(negedge ap_clk);
      cycles++;
      if (restart_at > 0 && cycles == restart_at) begin
        base_w[k]  = base ^ 24'h000040;
        start_w[k] = 1'b1;
      end else begin
        start_w[k] = 1'b0;
      end
    end
    start_w[k] = 1'b0;
    check($sformatf("done_seen%0d", k), cycles < limit, 1'b1);
    check($sformatf("csb_at_done%0d", k), csb_w[k], 1'b1);
    check($sformatf("busy_at_done%0d", k), busy_w[k], 1'b0);
    @(negedge ap_clk);
    check($sformatf("done_one_cycle%0d", k), done_w[k], 1'b0);
    repeat (2) @(negedge ap_clk);
    check($sformatf("wr_count%0d", k), wr_cnt[k] - wr_base[k], wc);
    check($sformatf("csb_low_cycles%0d", k), last_low[k], (32 + 32 * wc) * 2 * d + 2 * d);
    check($sformatf("cmd_addr%0d", k), cmdaddr[k], {8'h03, base});
    check($sformatf("sck_period_min%0d", k), per_min[k], 2 * d);
    check($sformatf("sck_period_max%0d", k), per_max[k], 2 * d);
  endtask

  task automatic run_zero(input int k);
    int falls0;
    int tog0;
    int wr0;
    falls0 = csb_falls[k];
    tog0   = sck_tog[k];
    wr0    = wr_cnt[k];
    @(negedge ap_clk);
    wc_w[k]    = '0;
    start_w[k] = 1'b1;
    @(negedge ap_clk);
    start_w[k] = 1'b0;
    check($sformatf("zero_done%0d", k), done_w[k], 1'b1);
    check($sformatf("zero_busy%0d", k), busy_w[k], 1'b0);
    @(negedge ap_clk);
    check($sformatf("zero_done_once%0d", k), done_w[k], 1'b0);
    repeat (3) @(negedge ap_clk);
    check($sformatf("zero_csb_falls%0d", k), csb_falls[k], falls0);
    check($sformatf("zero_sck_tog%0d", k), sck_tog[k], tog0);
    check($sformatf("zero_writes%0d", k), wr_cnt[k], wr0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [23:0] base;
    int          k;
    int          wc;
    for (int i = 0; i < N_DUT; i++) begin
      start_w[i] = 1'b0;
      base_w[i]  = '0;
      wc_w[i]    = '0;
    end
    for (int i = 0; i < MEM_N; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h6F; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h0B;

    // Reset state
    ap_rst = 1'b1;
    repeat (3) @(negedge ap_clk);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("rst_csb%0d", i), csb_w[i], 1'b1);
      check($sformatf("rst_sck%0d", i), sck_w[i], 1'b0);
      check($sformatf("rst_io0%0d", i), io0_w[i], 1'b0);
      check($sformatf("rst_busy%0d", i), busy_w[i], 1'b0);
      check($sformatf("rst_done%0d", i), done_w[i], 1'b0);
      check($sformatf("rst_en%0d", i), en_w[i], 1'b0);
      check($sformatf("rst_wen%0d", i), wen_w[i], 4'h0);
      check($sformatf("rst_addr%0d", i), addr_w[i], 32'h0);
      check($sformatf("rst_din%0d", i), din_w[i], 32'h0);
      check($sformatf("rst_rstA%0d", i), rrst_w[i], 1'b1);
      check($sformatf("clkA_low%0d", i), rclk_w[i], 1'b0);
    end
    @(posedge ap_clk);
    #1;
    check("clkA_high0", rclk_w[0], 1'b1);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rstA_released0", rrst_w[0], 1'b0);

    // Single word from address 0 (bytes 6F 00 00 0B)
    run_xfer(0, 24'h000000, 1, 0);
    // Three words from 0x100
    run_xfer(0, 24'h000100, 3, 0);
    // Zero-length request
    run_zero(0);
    // start re-pulsed during DATA must be ignored
    run_xfer(0, 24'($urandom_range(0, 400)), 3, 500);

    // Reset in the middle of the address phase
    base = 24'($urandom_range(0, 400));
    load_model(0, base, 0);
    @(negedge ap_clk);
    base_w[0]  = base;
    wc_w[0]    = 16'd2;
    start_w[0] = 1'b1;
    @(negedge ap_clk);
    start_w[0] = 1'b0;
    repeat (150) @(negedge ap_clk);
    check("mid_addr_reached", (rise_cnt[0] > 8) && (rise_cnt[0] < 32), 1'b1);
    #1 ap_rst = 1'b1;
    #1;
    check("arst_csb", csb_w[0], 1'b1);
    check("arst_sck", sck_w[0], 1'b0);
    check("arst_busy", busy_w[0], 1'b0);
    check("arst_io0", io0_w[0], 1'b0);
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    run_xfer(0, 24'($urandom_range(0, 400)), 2, 0);

    // Fastest divider
    run_xfer(1, 24'($urandom_range(0, 400)), 2, 0);
    run_zero(1);

    // Random transfers on both instances
    for (int r = 0; r < 6; r++) begin
      k  = r % 2;
      wc = $urandom_range(1, 5);
      run_xfer(k, 24'($urandom_range(0, 400)), wc, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
